// File: rtl/alarm_clock_pkg.sv
// Shared keypad codes, FSM state type and digit helpers for the alarm clock
// keypad sequencing path.
package alarm_clock_pkg;

    localparam int unsigned DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] NOKEY = 4'd10;
    localparam logic [DIGIT_W-1:0] ALARM = 4'd11;
    localparam logic [DIGIT_W-1:0] TIME  = 4'd12;

    typedef enum logic [2:0] {
        SHOW_TIME,
        KEY_STORED,
        KEY_WAITED,
        KEY_ENTRY,
        SHOW_ALARM,
        SET_ALARM_TIME,
        SET_CURRENT_TIME
    } state_t;

    function automatic logic is_digit(input logic [DIGIT_W-1:0] k);
        return k <= 4'd9;
    endfunction

    // Codes 13-15 are unused on the keypad and behave as a released key.
    function automatic logic is_nokey(input logic [DIGIT_W-1:0] k);
        return (k == NOKEY) || (k > TIME);
    endfunction

endpackage

// File: rtl/alarm_clock_fsm_if.sv
// Keypad-side inputs and datapath-side controls of the keypad sequencer.
interface alarm_clock_fsm_if;
    import alarm_clock_pkg::*;

    logic               one_second;
    logic [DIGIT_W-1:0] key;
    logic [DIGIT_W-1:0] key_buffer_ms_hr;
    logic [DIGIT_W-1:0] key_buffer_ls_hr;
    logic [DIGIT_W-1:0] key_buffer_ms_min;
    logic [DIGIT_W-1:0] key_buffer_ls_min;
    logic               load_new_alarm;
    logic               load_new_time;
    logic               show_alarm;
    logic               show_new_time;

    modport slave (
        input  one_second, key,
        output key_buffer_ms_hr, key_buffer_ls_hr, key_buffer_ms_min, key_buffer_ls_min,
        output load_new_alarm, load_new_time, show_alarm, show_new_time
    );

    modport master (
        output one_second, key,
        input  key_buffer_ms_hr, key_buffer_ls_hr, key_buffer_ms_min, key_buffer_ls_min,
        input  load_new_alarm, load_new_time, show_alarm, show_new_time
    );

endinterface

// File: rtl/key_reg.sv
// Four-digit entry buffer: each shift pushes a new digit in at ls_min and
// drops the oldest digit out of ms_hr.
module key_reg
    import alarm_clock_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               i_shift,
    input  logic               i_clear,
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [DIGIT_W-1:0] o_ms_hr,
    output logic [DIGIT_W-1:0] o_ls_hr,
    output logic [DIGIT_W-1:0] o_ms_min,
    output logic [DIGIT_W-1:0] o_ls_min
);

    logic [DIGIT_W-1:0] r_ms_hr;
    logic [DIGIT_W-1:0] r_ls_hr;
    logic [DIGIT_W-1:0] r_ms_min;
    logic [DIGIT_W-1:0] r_ls_min;

    always_ff @(posedge clock) begin
        if (!reset || i_clear) begin
            r_ms_hr  <= '0;
            r_ls_hr  <= '0;
            r_ms_min <= '0;
            r_ls_min <= '0;
        end else if (i_shift) begin
            r_ms_hr  <= r_ls_hr;
            r_ls_hr  <= r_ms_min;
            r_ms_min <= r_ls_min;
            r_ls_min <= i_digit;
        end
    end

    assign o_ms_hr  = r_ms_hr;
    assign o_ls_hr  = r_ls_hr;
    assign o_ms_min = r_ms_min;
    assign o_ls_min = r_ls_min;

endmodule

// File: rtl/alarm_clock_fsm.sv
// Keypad sequencing controller: Moore FSM turning keypad codes and the 1 Hz
// tick into load/display strobes, plus the digit entry buffer.
module alarm_clock_fsm
    import alarm_clock_pkg::*;
#(
    parameter int unsigned TIMEOUT_SEC = 10
) (
    input  logic              clock,
    input  logic              reset,
    alarm_clock_fsm_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_SEC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_SEC);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_count;
    logic [DIGIT_W-1:0] r_key_latched;
    logic               w_timeout;
    logic               w_counting;
    logic               w_digit;
    logic               w_nokey;

    assign w_digit    = is_digit(bus.key);
    assign w_nokey    = is_nokey(bus.key);
    assign w_timeout  = (r_count == CNT_MAX);
    assign w_counting = (r_state == KEY_WAITED) || (r_state == KEY_ENTRY);

    // Key decisions are tested before timeout so a key always wins a tie.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            SHOW_TIME: begin
                if (w_digit)               w_next = KEY_STORED;
                else if (bus.key == ALARM) w_next = SHOW_ALARM;
            end
            KEY_STORED: w_next = KEY_WAITED;
            KEY_WAITED: begin
                if (w_nokey)        w_next = KEY_ENTRY;
                else if (w_timeout) w_next = SHOW_TIME;
            end
            KEY_ENTRY: begin
                if (w_digit)               w_next = KEY_STORED;
                else if (bus.key == ALARM) w_next = SET_ALARM_TIME;
                else if (bus.key == TIME)  w_next = SET_CURRENT_TIME;
                else if (w_timeout)        w_next = SHOW_TIME;
            end
            SHOW_ALARM: begin
                if (w_nokey) w_next = SHOW_TIME;
            end
            SET_ALARM_TIME:   w_next = SHOW_TIME;
            SET_CURRENT_TIME: w_next = SHOW_TIME;
            default:          w_next = SHOW_TIME;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state       <= SHOW_TIME;
            r_key_latched <= '0;
        end else begin
            r_state <= w_next;
            if (w_next == KEY_STORED)
                r_key_latched <= bus.key;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset || !w_counting)
            r_count <= '0;
        else if (bus.one_second && !w_timeout)
            r_count <= r_count + 1'b1;
    end

    key_reg u_key_reg (
        .clock    (clock),
        .reset    (reset),
        .i_shift  (r_state == KEY_STORED),
        .i_clear  (r_state == SHOW_TIME),
        .i_digit  (r_key_latched),
        .o_ms_hr  (bus.key_buffer_ms_hr),
        .o_ls_hr  (bus.key_buffer_ls_hr),
        .o_ms_min (bus.key_buffer_ms_min),
        .o_ls_min (bus.key_buffer_ls_min)
    );

    assign bus.load_new_alarm = (r_state == SET_ALARM_TIME);
    assign bus.load_new_time  = (r_state == SET_CURRENT_TIME);
    assign bus.show_alarm     = (r_state == SHOW_ALARM);
    assign bus.show_new_time  = (r_state == KEY_STORED) || (r_state == KEY_WAITED) ||
                                (r_state == KEY_ENTRY);

endmodule

// File: tb/tb_alarm_clock_fsm.sv
// Self-checking bench for alarm_clock_fsm: directed scenarios plus a random
// key/tick run compared against a mode-level behavioural model.
module tb_alarm_clock_fsm;

    localparam int unsigned TO = 10;
    localparam logic [3:0] K_NONE  = 4'd10;
    localparam logic [3:0] K_ALARM = 4'd11;
    localparam logic [3:0] K_TIME  = 4'd12;

    // Model modes, independent of the RTL encoding.
    localparam int M_IDLE = 0, M_STORE = 1, M_WAIT = 2, M_ENTRY = 3,
                   M_ALSHOW = 4, M_LOADA = 5, M_LOADT = 6;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    alarm_clock_fsm_if bus ();

    alarm_clock_fsm #(.TIMEOUT_SEC(TO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [15:0] dut_buf();
        return {bus.key_buffer_ms_hr, bus.key_buffer_ls_hr,
                bus.key_buffer_ms_min, bus.key_buffer_ls_min};
    endfunction

    // Downstream observers: strobe cycle counts and an alarm register copy.
    int la_cnt = 0;
    int lt_cnt = 0;
    logic [15:0] alarm_reg = '0;
    always @(negedge clock) begin
        if (bus.load_new_alarm === 1'b1) la_cnt++;
        if (bus.load_new_time === 1'b1)  lt_cnt++;
    end
    always @(posedge clock)
        if (bus.load_new_alarm === 1'b1) alarm_reg <= dut_buf();

    // Behavioural model: the buffer is a 16-bit number extended by base-16 digits.
    int m_mode = M_IDLE;
    int m_secs = 0;
    int m_buf  = 0;
    int m_latch = 0;
    logic k_dig, k_alm, k_tim, k_none, k_to;
    always @(posedge clock) begin
        k_dig  = bus.key <= 4'd9;
        k_alm  = bus.key == K_ALARM;
        k_tim  = bus.key == K_TIME;
        k_none = !(k_dig || k_alm || k_tim);
        k_to   = m_secs == TO;
        if (!reset) begin
            m_mode = M_IDLE; m_secs = 0; m_buf = 0; m_latch = 0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    m_buf = 0; m_secs = 0;
                    if (k_dig) begin m_latch = int'(bus.key); m_mode = M_STORE; end
                    else if (k_alm) m_mode = M_ALSHOW;
                end
                M_STORE: begin
                    m_buf = (m_buf * 16 + m_latch) % 65536; m_secs = 0; m_mode = M_WAIT;
                end
                M_WAIT, M_ENTRY: begin
                    if (bus.one_second && m_secs < TO) m_secs = m_secs + 1;
                    if (m_mode == M_WAIT) begin
                        if (k_none) m_mode = M_ENTRY;
                        else if (k_to) m_mode = M_IDLE;
                    end else begin
                        if (k_dig) begin m_latch = int'(bus.key); m_mode = M_STORE; end
                        else if (k_alm) m_mode = M_LOADA;
                        else if (k_tim) m_mode = M_LOADT;
                        else if (k_to) m_mode = M_IDLE;
                    end
                    if (m_mode != M_WAIT && m_mode != M_ENTRY) m_secs = 0;
                end
                M_ALSHOW: begin
                    m_secs = 0;
                    if (k_none) m_mode = M_IDLE;
                end
                default: begin m_secs = 0; m_mode = M_IDLE; end
            endcase
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [3:0] k, input int n);
        bus.key = k;
        repeat (n) cyc();
    endtask

    task automatic press(input logic [3:0] d, input int hold, input int gap);
        drive(d, hold);
        drive(K_NONE, gap);
    endtask

    task automatic do_reset();
        bus.key = K_NONE; bus.one_second = 1'b0; reset = 1'b0;
        cyc(); cyc();
        reset = 1'b1;
        la_cnt = 0; lt_cnt = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        press(4'd5, 3, 0);
        reset = 1'b0; bus.key = 4'd5;
        cyc(); cyc();
        n_cmp++;
        if (dut_buf() !== 16'h0000) begin
            $display("FAIL reset_buf: got %h expected 0000", dut_buf()); n_bad++;
        end
        n_cmp++;
        if ({bus.load_new_alarm, bus.load_new_time, bus.show_alarm, bus.show_new_time} !== 4'b0000) begin
            $display("FAIL reset_strobes: got %b expected 0000",
                     {bus.load_new_alarm, bus.load_new_time, bus.show_alarm, bus.show_new_time});
            n_bad++;
        end
        reset = 1'b1; bus.key = K_NONE;
    endtask

    task automatic test_alarm_entry();
        do_reset();
        press(4'd1, 3, 2); press(4'd2, 3, 2); press(4'd3, 3, 2); press(4'd0, 3, 2);
        n_cmp++;
        if (dut_buf() !== 16'h1230) begin
            $display("FAIL alarm_buf: got %h expected 1230", dut_buf()); n_bad++;
        end
        drive(K_ALARM, 1);
        n_cmp++;
        if (bus.load_new_alarm !== 1'b1) begin
            $display("FAIL alarm_strobe: got %b expected 1", bus.load_new_alarm); n_bad++;
        end
        drive(K_NONE, 3);
        n_cmp++;
        if (la_cnt !== 1 || lt_cnt !== 0) begin
            $display("FAIL alarm_strobe_count: got %0d/%0d expected 1/0", la_cnt, lt_cnt); n_bad++;
        end
        n_cmp++;
        if (alarm_reg !== 16'h1230) begin
            $display("FAIL alarm_reg: got %h expected 1230", alarm_reg); n_bad++;
        end
    endtask

    task automatic test_digit_overflow();
        do_reset();
        for (int d = 1; d <= 5; d++) press(4'(d), 2, 2);
        n_cmp++;
        if (dut_buf() !== 16'h2345) begin
            $display("FAIL overflow_buf: got %h expected 2345", dut_buf()); n_bad++;
        end
        drive(K_TIME, 1);
        n_cmp++;
        if (bus.load_new_time !== 1'b1) begin
            $display("FAIL time_strobe: got %b expected 1", bus.load_new_time); n_bad++;
        end
        drive(K_NONE, 3);
        n_cmp++;
        if (lt_cnt !== 1 || la_cnt !== 0) begin
            $display("FAIL time_strobe_count: got %0d/%0d expected 1/0", lt_cnt, la_cnt); n_bad++;
        end
    endtask

    task automatic test_held_key();
        do_reset();
        press(4'd7, 20, 2);
        n_cmp++;
        if (dut_buf() !== 16'h0007 || bus.show_new_time !== 1'b1) begin
            $display("FAIL held_key: got %h/%b expected 0007/1", dut_buf(), bus.show_new_time); n_bad++;
        end
    endtask

    task automatic ten_ticks();
        for (int i = 0; i < 10; i++) begin
            bus.one_second = 1'b1; cyc();
            bus.one_second = 1'b0;
            if (i != 9) begin cyc(); cyc(); end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        drive(4'd9, 1); drive(K_NONE, 2);
        ten_ticks();
        n_cmp++;
        if (bus.show_new_time !== 1'b1) begin
            $display("FAIL timeout_early: got %b expected 1", bus.show_new_time); n_bad++;
        end
        cyc();
        n_cmp++;
        if (bus.show_new_time !== 1'b0) begin
            $display("FAIL timeout_fire: got %b expected 0", bus.show_new_time); n_bad++;
        end
        cyc();
        n_cmp++;
        if (dut_buf() !== 16'h0000 || la_cnt !== 0 || lt_cnt !== 0) begin
            $display("FAIL timeout_clear: got %h la=%0d lt=%0d expected 0000 0 0", dut_buf(), la_cnt, lt_cnt);
            n_bad++;
        end
        do_reset();
        drive(4'd9, 1); drive(K_NONE, 2);
        ten_ticks();
        drive(4'd4, 1);
        n_cmp++;
        if (bus.show_new_time !== 1'b1) begin
            $display("FAIL timeout_tie: got %b expected 1", bus.show_new_time); n_bad++;
        end
        drive(K_NONE, 1);
        n_cmp++;
        if (dut_buf() !== 16'h0094) begin
            $display("FAIL timeout_tie_buf: got %h expected 0094", dut_buf()); n_bad++;
        end
    endtask

    task automatic test_show_alarm_reset();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(K_ALARM, 1);
            n_cmp++;
            if (bus.show_alarm !== 1'b1) begin
                $display("FAIL show_alarm_held: got %b expected 1", bus.show_alarm); n_bad++;
            end
        end
        drive(K_NONE, 1);
        n_cmp++;
        if (bus.show_alarm !== 1'b0) begin
            $display("FAIL show_alarm_release: got %b expected 0", bus.show_alarm); n_bad++;
        end
        press(4'd6, 2, 2);
        n_cmp++;
        if (bus.show_new_time !== 1'b1) begin
            $display("FAIL entry_before_reset: got %b expected 1", bus.show_new_time); n_bad++;
        end
        reset = 1'b0; bus.key = K_ALARM;
        cyc();
        reset = 1'b1; bus.key = K_NONE;
        n_cmp++;
        if ({bus.load_new_alarm, bus.load_new_time, bus.show_alarm, bus.show_new_time} !== 4'b0000
            || la_cnt !== 0) begin
            $display("FAIL mid_entry_reset: got %b la=%0d expected 0000 0",
                     {bus.load_new_alarm, bus.load_new_time, bus.show_alarm, bus.show_new_time}, la_cnt);
            n_bad++;
        end
    endtask

    task automatic test_random();
        logic [3:0] k;
        int sel, hold;
        logic [19:0] got, exp;
        do_reset();
        for (int c = 0; c < 3000; c += hold) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 50)      k = 4'($urandom_range(0, 9));
            else if (sel < 85) k = 4'($urandom_range(13, 16) == 16 ? 10 : $urandom_range(13, 15));
            else if (sel < 93) k = K_ALARM;
            else               k = K_TIME;
            hold = int'($urandom_range(1, 4));
            bus.key = k;
            for (int h = 0; h < hold; h++) begin
                bus.one_second = ($urandom_range(0, 3) == 0);
                reset = ($urandom_range(0, 299) != 0);
                cyc();
                got = {bus.load_new_alarm, bus.load_new_time, bus.show_alarm, bus.show_new_time, dut_buf()};
                exp = {m_mode == M_LOADA, m_mode == M_LOADT, m_mode == M_ALSHOW,
                       m_mode == M_STORE || m_mode == M_WAIT || m_mode == M_ENTRY, 16'(m_buf)};
                n_cmp++;
                if (got !== exp) begin
                    $display("FAIL random_cycle %0d: got %h expected %h", c + h, got, exp);
                    n_bad++;
                end
            end
        end
        reset = 1'b1; bus.one_second = 1'b0; bus.key = K_NONE;
    endtask

    initial begin
        bus.key = K_NONE;
        bus.one_second = 1'b0;
        test_reset();
        test_alarm_entry();
        test_digit_overflow();
        test_held_key();
        test_timeout();
        test_show_alarm_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alarm_clock_fsm.md
# alarm_clock_fsm

Keypad sequencing controller for the alarm clock. It turns raw keypad codes and the 1 Hz tick into the control strobes that drive the alarm register, the time counter and the display mux. It also owns the four-digit key entry buffer whose outputs feed `new_alarm_*` on the alarm register and `new_time_*` on the counter. It sits between the keypad scanner and the `alarm_reg`/counter/display datapath.

## Interface
- `TIMEOUT_SEC`, 10: number of `one_second` ticks without a key in the entry states before entry is abandoned.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset, sampled on the rising edge of `clock`.
- `one_second`  in  1  one-cycle pulse at 1 Hz.
- `key`  in  4  keypad code: 0–9 digit, 10 `NOKEY`, 11 `ALARM`, 12 `TIME`; 13–15 treated as `NOKEY`.
- `key_buffer_ms_hr`, `key_buffer_ls_hr`, `key_buffer_ms_min`, `key_buffer_ls_min`  out  4 each  entered digits; wired to `new_alarm_*` / `new_time_*`.
- `load_new_alarm`  out  1  one-cycle strobe to the alarm register.
- `load_new_time`  out  1  one-cycle strobe to the time counter.
- `show_alarm`  out  1  display selects the alarm time.
- `show_new_time`  out  1  display selects the key buffer.

## Operation
- The FSM is Moore, one-hot or binary (implementer's choice). It has 7 states: `SHOW_TIME`, `KEY_STORED`, `KEY_WAITED`, `KEY_ENTRY`, `SHOW_ALARM`, `SET_ALARM_TIME`, `SET_CURRENT_TIME`.
- **Transitions:**
  - `SHOW_TIME`:
    - digit → `KEY_STORED`
    - `ALARM` → `SHOW_ALARM`
    - else stay
  - `KEY_STORED` → `KEY_WAITED`, unconditionally.
  - `KEY_WAITED`:
    - `NOKEY` → `KEY_ENTRY` (key released)
    - else timeout → `SHOW_TIME`
    - else stay
  - `KEY_ENTRY`:
    - digit → `KEY_STORED`
    - `ALARM` → `SET_ALARM_TIME`
    - `TIME` → `SET_CURRENT_TIME`
    - else timeout → `SHOW_TIME`
    - else stay
  - `SHOW_ALARM`: `NOKEY` → `SHOW_TIME`, else stay.
  - `SET_ALARM_TIME` → `SHOW_TIME`, unconditionally.
  - `SET_CURRENT_TIME` → `SHOW_TIME`, unconditionally.
- **Moore outputs:**
  - `load_new_alarm` = 1 only in `SET_ALARM_TIME`.
  - `load_new_time` = 1 only in `SET_CURRENT_TIME`.
  - `show_alarm` = 1 only in `SHOW_ALARM`.
  - `show_new_time` = 1 in `KEY_STORED`, `KEY_WAITED`, `KEY_ENTRY`.
- **Key capture:** on any transition into `KEY_STORED`, `key` is latched into an internal 4-bit `key_latched`.
- **Key buffer shift:** in `KEY_STORED` the buffer shifts left by one digit:
  - ms_hr ← ls_hr
  - ls_hr ← ms_min
  - ms_min ← ls_min
  - ls_min ← `key_latched`
  - More than 4 digits: the oldest digit is discarded.
- **Key buffer clear:** the buffer is cleared to 0 every cycle the FSM is in `SHOW_TIME`.
- No range checking of the entered digits; out-of-range values pass through unchanged.
- **Timeout counter:**
  - Width ⌈log2(TIMEOUT_SEC+1)⌉.
  - Cleared in every state except `KEY_WAITED` and `KEY_ENTRY`.
  - In those two states it increments on `one_second` and saturates at `TIMEOUT_SEC`.
  - timeout = (count == `TIMEOUT_SEC`).
- **Priority:** a valid key action always beats timeout in the same cycle.
- **Reset** (`reset`=0 at an edge, any state, including mid-entry):
  - state `SHOW_TIME`
  - counter 0
  - buffer 0
  - `key_latched` 0
  - all strobes 0

## Timing
- All outputs are registered or decoded from registered state, with no combinational path from `key` to outputs.
- **Digit path:**
  - Digit sampled at edge N → state `KEY_STORED` and `show_new_time`=1 after edge N.
  - Buffer updated after edge N+1.
- **Alarm load:** `ALARM` sampled in `KEY_ENTRY` at edge N → `load_new_alarm` high for exactly cycle N..N+1. The alarm register captures the buffer at edge N+1.
- **Held keys:** a key held for many cycles produces exactly one shift, because `KEY_WAITED` blocks until `NOKEY`.
- **Timeout:** the timeout fires at the first edge after the `TIMEOUT_SEC`-th `one_second` pulse seen in `KEY_WAITED`/`KEY_ENTRY`.

## Structure
- Package `alarm_clock_pkg` holds:
  - key code constants: `NOKEY`=10, `ALARM`=11, `TIME`=12
  - state encoding constants
  - digit width 4
- One natural sub-module: `key_reg` (4-digit shift buffer with `shift` and `clear` inputs), instantiated by `alarm_clock_fsm`. It is shared later with the time-set path.

## Test plan
- **Reset:** hold `reset`=0 for 2 cycles with `key`=5 → state `SHOW_TIME`, all four buffer digits 0, all strobes 0.
- **Alarm entry:** keys 1,2,3,0, each held 3 cycles separated by 2 cycles of `NOKEY`, then `ALARM` → buffer 1/2/3/0, `load_new_alarm` exactly one cycle. The downstream `alarm_reg` then reads 1,2,3,0.
- **Digit overflow:** keys 1,2,3,4,5 then `TIME` → buffer 2/3/4/5, `load_new_time` one cycle, `load_new_alarm` stays 0.
- **Held key:** key 7 held 20 cycles, then `NOKEY` → exactly one shift; ls_min=7, other digits 0.
- **Timeout:** with `TIMEOUT_SEC`=10, enter digit 9, then `NOKEY` with 10 `one_second` pulses → return to `SHOW_TIME` after the 10th, buffer 0, no load strobe. Repeat with a digit arriving in the same cycle as the timeout → `KEY_STORED` wins.
- **Show alarm and mid-entry reset:** `ALARM` from `SHOW_TIME` → `show_alarm`=1 while held, 0 one cycle after `NOKEY`. Assert `reset` while in `KEY_ENTRY` → `SHOW_TIME` next edge, no strobe.
